rom_burst_reader: RTL and testbench

Initiator-side controller for the team's synchronous 4x4 ROM. On a `start` request it issues a burst of ROM reads by driving `rom_en`/`rom_addr`. It absorbs the ROM's one-cycle read latency, and presents each word on a valid/ready output stream with its address, a last-word flag and a running XOR checksum. It sits between the ROM and any consumer that needs back-pressured sequential access.

---
 rtl/rom_burst_reader.sv | 106 ++++++++++
 tb/tb_rom_burst_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Burst read controller for the synchronous ROM.
// Issues one read per word, absorbs read latency, streams words out.
module rom_burst_reader #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W:0]   remain, remain_d;
    logic [DATA_W-1:0] cksum_d;
    logic              hs;

    assign out_valid = (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        remain_d = remain;
        cksum_d  = checksum;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    ptr_d    = start_addr;
                    remain_d = (count == '0) ? FULL : count;
                    cksum_d  = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_HOLD;
            S_HOLD: begin
                if (hs) begin
                    cksum_d  = checksum ^ out_data;
                    remain_d = remain - ONE;
                    ptr_d    = ptr + 1'b1;
                    state_d  = out_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            remain   <= '0;
            checksum <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            remain   <= remain_d;
            checksum <= cksum_d;
            // Read strobe is registered so it covers exactly the ISSUE cycle.
            rom_en   <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) begin
                rom_addr <= ptr_d;
            end
            if (state == S_WAIT) begin
                out_data <= rom_data;
                out_addr <= ptr;
                out_last <= (remain == ONE);
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader with a 1-cycle ROM model
// and a sequence-level reference model of each burst.
module tb_rom_burst_reader;

    localparam int AW = 2;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    rom_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_addr(start_addr), .count(count),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [4] = '{4'hA, 4'h5, 4'hC, 4'h3};

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    int checks = 0;
    int failures = 0;

    // Observed burst results
    logic [31:0]   got_sig;
    int            got_n;
    logic [DW-1:0] got_ck;
    int            en_cnt, done_cnt, en_viol, unstable;
    bit            timed_out;

    // Expected burst results
    logic [31:0]   exp_sig;
    int            exp_n;
    logic [DW-1:0] exp_ck;

    task automatic build_expect(input logic [AW-1:0] sa, input logic [AW:0] cnt);
        int n;
        int a;
        n = (cnt == 0) ? 4 : int'(cnt);
        exp_sig = '0;
        exp_ck = '0;
        exp_n = n;
        for (int i = 0; i < n; i++) begin
            a = (int'(sa) + i) % 4;
            exp_sig = (exp_sig << 8) | {25'd0, (i == n - 1), 2'(a), mem[a]};
            exp_ck ^= mem[a];
        end
    endtask

    task automatic do_burst(input logic [AW-1:0] sa, input logic [AW:0] cnt,
                            input int lo, input int hi, input bit inject);
        int stall, cyc, post;
        bit prev_en, seen_done, hv;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        got_sig = '0; got_n = 0; en_cnt = 0; done_cnt = 0;
        en_viol = 0; unstable = 0;
        cyc = 0; post = 0; prev_en = 0; seen_done = 0; hv = 0;
        hd = '0; ha = '0;
        @(negedge clk);
        start = 1; start_addr = sa; count = cnt; out_ready = 0;
        stall = $urandom_range(hi, lo);
        while (post < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (rom_en) en_cnt++;
            if (rom_en && prev_en) en_viol++;
            prev_en = rom_en;
            if (done) begin
                done_cnt++;
                seen_done = 1;
            end
            if (seen_done) post++;
            if (out_valid) begin
                if (hv && (out_data !== hd || out_addr !== ha)) unstable++;
                hd = out_data; ha = out_addr; hv = 1;
                if (stall == 0) begin
                    out_ready = 1;
                    got_sig = (got_sig << 8) | {25'd0, out_last, out_addr, out_data};
                    got_n++;
                    hv = 0;
                    stall = $urandom_range(hi, lo);
                    if (inject && got_n == 1) begin
                        start = 1; start_addr = sa + 2'd2; count = 1;
                    end
                end else begin
                    out_ready = 0;
                    stall--;
                end
            end else begin
                out_ready = 1'($urandom_range(1, 0));
            end
        end
        out_ready = 0;
        timed_out = !seen_done;
        got_ck = checksum;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++;
        if ({rom_en, rom_addr, out_valid, out_data, out_addr, out_last,
             busy, done, checksum} !== '0) begin
            failures++;
            $display("FAIL reset_state got en=%b va=%b busy=%b done=%b ck=%h req all zero",
                     rom_en, out_valid, busy, done, checksum);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_full_burst();
        do_burst(2'd0, 3'd4, 0, 0, 0);
        build_expect(2'd0, 3'd4);
        checks++;
        if (got_sig !== exp_sig || got_n != exp_n) begin
            failures++;
            $display("FAIL full_seq got %h/%0d req %h/%0d", got_sig, got_n, exp_sig, exp_n);
        end
        checks++;
        if (got_ck !== exp_ck) begin
            failures++;
            $display("FAIL full_cksum got %h req %h", got_ck, exp_ck);
        end
        checks++;
        if (en_cnt != 4 || en_viol != 0) begin
            failures++;
            $display("FAIL full_rom_en got %0d pulses %0d viol req 4/0", en_cnt, en_viol);
        end
        checks++;
        if (done_cnt != 1 || timed_out) begin
            failures++;
            $display("FAIL full_done got %0d timeout=%b req 1/0", done_cnt, timed_out);
        end
    endtask

    task automatic test_wrap();
        do_burst(2'd3, 3'd3, 0, 1, 0);
        build_expect(2'd3, 3'd3);
        checks++;
        if (got_sig !== exp_sig || got_n != exp_n) begin
            failures++;
            $display("FAIL wrap_seq got %h/%0d req %h/%0d", got_sig, got_n, exp_sig, exp_n);
        end
        checks++;
        if (got_ck !== exp_ck || en_cnt != 3) begin
            failures++;
            $display("FAIL wrap_cksum got %h en=%0d req %h en=3", got_ck, en_cnt, exp_ck);
        end
        do_burst(2'd2, 3'd0, 0, 1, 0);
        build_expect(2'd2, 3'd0);
        checks++;
        if (got_sig !== exp_sig || got_n != 4 || en_cnt != 4) begin
            failures++;
            $display("FAIL count0_seq got %h/%0d en=%0d req %h/4 en=4",
                     got_sig, got_n, en_cnt, exp_sig);
        end
    endtask

    task automatic test_backpressure();
        do_burst(2'd0, 3'd4, 5, 5, 0);
        build_expect(2'd0, 3'd4);
        checks++;
        if (got_sig !== exp_sig || got_ck !== exp_ck) begin
            failures++;
            $display("FAIL bp_seq got %h ck=%h req %h ck=%h", got_sig, got_ck, exp_sig, exp_ck);
        end
        checks++;
        if (unstable != 0 || en_cnt != 4 || en_viol != 0) begin
            failures++;
            $display("FAIL bp_stable got unstable=%0d en=%0d viol=%0d req 0/4/0",
                     unstable, en_cnt, en_viol);
        end
    endtask

    task automatic test_ignored_start();
        do_burst(2'd0, 3'd4, 0, 2, 1);
        build_expect(2'd0, 3'd4);
        checks++;
        if (got_sig !== exp_sig || got_ck !== exp_ck) begin
            failures++;
            $display("FAIL ign_seq got %h ck=%h req %h ck=%h", got_sig, got_ck, exp_sig, exp_ck);
        end
        checks++;
        if (en_cnt != 4 || done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_no_new got en=%0d done=%0d busy=%b req 4/1/0",
                     en_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int en_in_rst;
        found = 0;
        en_in_rst = 0;
        @(negedge clk);
        start = 1; start_addr = 0; count = 4; out_ready = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_addr == 2'd1) begin
                out_ready = 0;
                found = 1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_reach got no HOLD of word 2 req HOLD");
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({rom_en, rom_addr, out_valid, out_data, out_addr, out_last,
             busy, done, checksum} !== '0) begin
            failures++;
            $display("FAIL rstmid_zero got va=%b data=%h busy=%b ck=%h req all zero",
                     out_valid, out_data, busy, checksum);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rom_en) en_in_rst++;
        end
        rst_n = 1;
        checks++;
        if (en_in_rst != 0) begin
            failures++;
            $display("FAIL rstmid_en got %0d pulses req 0", en_in_rst);
        end
        do_burst(2'd1, 3'd1, 0, 0, 0);
        build_expect(2'd1, 3'd1);
        checks++;
        if (got_sig !== exp_sig || got_ck !== exp_ck || en_cnt != 1) begin
            failures++;
            $display("FAIL rstmid_after got %h ck=%h en=%0d req %h ck=%h en=1",
                     got_sig, got_ck, en_cnt, exp_sig, exp_ck);
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] w;
        w = mem[2];
        @(negedge clk);
        start = 1; start_addr = 2; count = 1; out_ready = 1;
        @(posedge clk);
        #1 start = 0;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_e got en=%b addr=%0d busy=%b va=%b req 1/2/1/0",
                     rom_en, rom_addr, busy, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rom_en !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_e1 got en=%b va=%b req 0/0", rom_en, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== w || out_last !== 1'b1) begin
            failures++;
            $display("FAIL lat_e2 got va=%b data=%h last=%b req 1/%h/1",
                     out_valid, out_data, out_last, w);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_done got done=%b va=%b req 1/0", done, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || checksum !== w) begin
            failures++;
            $display("FAIL lat_idle got done=%b busy=%b ck=%h req 0/0/%h",
                     done, busy, checksum, w);
        end
        out_ready = 0;
    endtask

    task automatic test_random();
        logic [AW-1:0] sa;
        logic [AW:0]   cnt;
        for (int k = 0; k < 10; k++) begin
            sa  = AW'($urandom_range(3, 0));
            cnt = (AW+1)'($urandom_range(4, 0));
            do_burst(sa, cnt, 0, 3, 1'($urandom_range(1, 0)));
            build_expect(sa, cnt);
            checks++;
            if (got_sig !== exp_sig || got_n != exp_n || got_ck !== exp_ck) begin
                failures++;
                $display("FAIL rand_seq[%0d] sa=%0d cnt=%0d got %h/%0d ck=%h req %h/%0d ck=%h",
                         k, sa, cnt, got_sig, got_n, got_ck, exp_sig, exp_n, exp_ck);
            end
            checks++;
            if (en_cnt != exp_n || en_viol != 0 || done_cnt != 1 || unstable != 0) begin
                failures++;
                $display("FAIL rand_ctl[%0d] got en=%0d viol=%0d done=%0d unst=%0d req %0d/0/1/0",
                         k, en_cnt, en_viol, done_cnt, unstable, exp_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
